// File: rtl/pipe_skid_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage_if
// Description : Handshake bundle for pipe_skid_stage. It carries the producer
//               side (in_*), the consumer side (out_*) and the occupancy
//               status. The slave modport is the stage's view of the bundle.
//               The master modport is the environment's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_skid_stage_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       occupancy;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, occupancy
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, occupancy
  );
endinterface
`default_nettype wire

// File: rtl/pipe_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : pipe_skid_stage
// Description : Elastic valid/ready stage with one main register and one skid
//               register. Every output is driven straight from a flop, so the
//               consumer's ready signal never reaches in_ready through
//               combinational logic. The stage sustains one transfer per
//               cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_skid_stage #(
  parameter int WIDTH = 8
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  pipe_skid_stage_if.slave       bus
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] BUSY  = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [1:0]       occ_q;
  logic             push;
  logic             pop;

  // Handshakes are qualified only by registered flags.
  assign push = bus.in_valid & in_ready_q;
  assign pop  = out_valid_q & bus.out_ready;

  // Next-state and storage selection. in_data is only sampled on a push.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = BUSY;
          main_d  = bus.in_data;
        end
      end
      BUSY: begin
        if (push && pop) begin
          main_d = bus.in_data;
        end else if (push) begin
          state_d = FULL;
          skid_d  = bus.in_data;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, storage and the status flags decoded from the next state. The
  // flags therefore come from flops and track state_q exactly. in_ready
  // stays low during reset and rises on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != FULL);
      out_valid_q <= (state_d != EMPTY);
      occ_q       <= (state_d == FULL) ? 2'd2 :
                     (state_d == BUSY) ? 2'd1 : 2'd0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = main_q;
  assign bus.occupancy = occ_q;

endmodule
`default_nettype wire
